systolic_result_drain: RTL and testbench

Result-side companion to the systolic array multiplier. It captures the array's flattened C matrix on the array's one-cycle `done` pulse, then streams the M×N accumulators out one element per transfer in row-major order over a valid/ready interface. It is the reader/serializer at the far end of the array, the counterpart of the row/column PISO feed on the input side. It frees the array for the next `start` as soon as the capture is made.

---
 rtl/systolic_result_drain.sv | 158 +++++++++++++++
 tb/tb_systolic_result_drain.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/systolic_result_drain.sv
// Captures the systolic array's C matrix on `done` and streams it row-major over valid/ready.
// Optional signed clamping to OUT_WIDTH is enabled by defining RESULT_SAT_EN.
module systolic_result_drain #(
  parameter int M         = 6,
  parameter int N         = 6,
  parameter int ACC_WIDTH = 35,
  parameter int OUT_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       done,
  input  logic [M*N*ACC_WIDTH-1:0]   C_flat,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_WIDTH-1:0]       out_data,
  output logic                       out_row_last,
  output logic                       out_last,
  output logic                       out_sat,
  output logic                       busy,
  output logic                       drain_done,
  output logic                       overrun
);

  localparam int ROW_W = (M > 1) ? $clog2(M) : 1;
  localparam int COL_W = (N > 1) ? $clog2(N) : 1;
  localparam int IDX_W = (M * N > 1) ? $clog2(M * N) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                              state_r;
  state_t                              state_nxt_s;
  logic [M*N-1:0][ACC_WIDTH-1:0]       buf_r;
  logic [ROW_W-1:0]                    row_r;
  logic [COL_W-1:0]                    col_r;
  logic                                drain_done_r;
  logic                                overrun_r;
  logic                                capture_s;
  logic                                xfer_s;
  logic                                col_last_s;
  logic                                row_last_s;
  logic                                elem_last_s;
  logic [IDX_W-1:0]                    elem_idx_s;
  logic [ACC_WIDTH-1:0]                elem_s;

  assign col_last_s  = (col_r == COL_W'(N - 1));
  assign row_last_s  = (row_r == ROW_W'(M - 1));
  assign elem_last_s = col_last_s && row_last_s;
  assign xfer_s      = (state_r == DRAIN) && out_ready;
  assign elem_idx_s  = IDX_W'(row_r) * IDX_W'(N) + IDX_W'(col_r);
  assign elem_s      = buf_r[elem_idx_s];

  // Next-state logic: capture from IDLE, leave DRAIN on the final transfer
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (done) begin
          state_nxt_s = DRAIN;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRAIN: begin
        if (xfer_s && elem_last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Result buffer; a `done` seen while draining is ignored so the stream stays intact
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_r <= '0;
    end else if (capture_s) begin
      buf_r <= C_flat;
    end
  end

  // Row/column position of the element currently presented
  always_ff @(posedge clk) begin
    if (rst || capture_s) begin
      row_r <= '0;
      col_r <= '0;
    end else if (xfer_s) begin
      if (col_last_s) begin
        col_r <= '0;
        row_r <= row_last_s ? '0 : row_r + ROW_W'(1);
      end else begin
        col_r <= col_r + COL_W'(1);
      end
    end
  end

  // Status pulses, each one cycle after its cause
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_done_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      drain_done_r <= xfer_s && elem_last_s;
      overrun_r    <= done && (state_r == DRAIN);
    end
  end

  assign out_valid    = (state_r == DRAIN);
  assign busy         = (state_r == DRAIN);
  assign out_row_last = col_last_s;
  assign out_last     = elem_last_s;
  assign drain_done   = drain_done_r;
  assign overrun      = overrun_r;

`ifdef RESULT_SAT_EN
  // Returns {sat, data}; in range when every bit from the output sign bit upward matches
  function automatic logic [OUT_WIDTH:0] sat_f(input logic [ACC_WIDTH-1:0] v);
    logic [ACC_WIDTH-OUT_WIDTH:0] hi;
    logic [OUT_WIDTH-1:0]         mn;
    hi            = v[ACC_WIDTH-1:OUT_WIDTH-1];
    mn            = '0;
    mn[OUT_WIDTH-1] = 1'b1;
    if ((&hi) || (~|hi)) begin
      sat_f = {1'b0, v[OUT_WIDTH-1:0]};
    end else if (v[ACC_WIDTH-1]) begin
      sat_f = {1'b1, mn};
    end else begin
      sat_f = {1'b1, ~mn};
    end
  endfunction

  assign {out_sat, out_data} = sat_f(elem_s);
`else
  logic unused_elem_s;

  assign out_data      = elem_s[OUT_WIDTH-1:0];
  assign out_sat       = 1'b0;
  assign unused_elem_s = ^elem_s;
`endif

endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for systolic_result_drain (M=N=2): drain, backpressure, overrun, reset, saturation.
module tb_systolic_result_drain;

  localparam int M   = 2;
  localparam int N   = 2;
  localparam int ACC = 35;
  localparam int OW  = 32;

  typedef struct {
    logic [OW-1:0] data;
    logic          row_last;
    logic          last;
    logic          sat;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 done;
  logic [M*N*ACC-1:0]   C_flat;
  logic                 out_valid;
  logic                 out_ready;
  logic [OW-1:0]        out_data;
  logic                 out_row_last;
  logic                 out_last;
  logic                 out_sat;
  logic                 busy;
  logic                 drain_done;
  logic                 overrun;

  int     total = 0;
  int     bad   = 0;
  exp_t   sb_q[$];
  longint cv[M*N];
  bit     m_drain = 1'b0;
  bit     m_dd    = 1'b0;
  bit     m_ov    = 1'b0;

  systolic_result_drain #(.M(M), .N(N), .ACC_WIDTH(ACC), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .done(done), .C_flat(C_flat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row_last(out_row_last), .out_last(out_last), .out_sat(out_sat),
    .busy(busy), .drain_done(drain_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference conversion: {sat, data}
  function automatic logic [OW:0] conv(input longint v);
`ifdef RESULT_SAT_EN
    if (v > 64'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
    if (v < -64'sd2147483648) return {1'b1, 32'h8000_0000};
`endif
    return {1'b0, v[OW-1:0]};
  endfunction

  task automatic load_c(input longint a, input longint b, input longint c, input longint d);
    cv[0] = a; cv[1] = b; cv[2] = c; cv[3] = d;
    for (int k = 0; k < M*N; k++) C_flat[k*ACC +: ACC] = cv[k][ACC-1:0];
  endtask

  // One clock: drive inputs, check at negedge, advance the reference model
  task automatic step(input logic d, input logic rd, input logic r);
    bit   xfer;
    exp_t e;
    logic [OW:0] cvt;
    done = d; out_ready = rd; rst = r;
    @(negedge clk);
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_drain});
    chk("busy", {63'd0, busy}, {63'd0, m_drain});
    chk("drain_done", {63'd0, drain_done}, {63'd0, m_dd});
    chk("overrun", {63'd0, overrun}, {63'd0, m_ov});
    if (m_drain && sb_q.size() > 0) begin
      chk("out_data", {32'd0, out_data}, {32'd0, sb_q[0].data});
      chk("out_row_last", {63'd0, out_row_last}, {63'd0, sb_q[0].row_last});
      chk("out_last", {63'd0, out_last}, {63'd0, sb_q[0].last});
      chk("out_sat", {63'd0, out_sat}, {63'd0, sb_q[0].sat});
    end
    xfer = m_drain && rd;
    if (r) begin
      sb_q.delete();
      m_drain = 1'b0; m_dd = 1'b0; m_ov = 1'b0;
    end else begin
      m_ov = d && m_drain;
      m_dd = 1'b0;
      if (xfer) begin
        void'(sb_q.pop_front());
        if (sb_q.size() == 0) begin
          m_drain = 1'b0;
          m_dd    = 1'b1;
        end
      end else if (!m_drain && d) begin
        for (int k = 0; k < M*N; k++) begin
          cvt        = conv(cv[k]);
          e.data     = cvt[OW-1:0];
          e.sat      = cvt[OW];
          e.row_last = ((k % N) == N - 1);
          e.last     = (k == M*N - 1);
          sb_q.push_back(e);
        end
        m_drain = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1; done = 1'b0; out_ready = 1'b0; C_flat = '0;
    load_c(64'sd1, 64'sd2, 64'sd3, 64'sd4);
    @(posedge clk); #1;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);

    // Basic drain: drain_done five cycles after done
    step(1'b1, 1'b1, 1'b0);
    n = 1;
    while (!drain_done && n < 20) begin step(1'b0, 1'b1, 1'b0); n++; end
    chk("basic_len", 64'(n), 64'd5);
    step(1'b0, 1'b1, 1'b0);

    // Backpressure: ready low three cycles on element 2
    load_c(64'sd11, 64'sd12, 64'sd13, 64'sd14);
    step(1'b1, 1'b1, 1'b0);
    n = 1;
    while (!drain_done && n < 20) begin
      step(1'b0, (n >= 2 && n <= 4) ? 1'b0 : 1'b1, 1'b0);
      n++;
    end
    chk("stall_len", 64'(n), 64'd8);
    step(1'b0, 1'b0, 1'b0);

    // Overrun on element 3 and on the final transfer; new drain in drain_done cycle
    load_c(64'sd21, 64'sd22, 64'sd23, 64'sd24);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    load_c(-64'sd31, 64'sd32, -64'sd33, 64'sd34);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("ov_dd_cycle", {63'd0, drain_done}, 64'd1);
    step(1'b1, 1'b1, 1'b0);
    n = 1;
    while (!drain_done && n < 20) begin step(1'b0, 1'b1, 1'b0); n++; end
    chk("ov_redrain_len", 64'(n), 64'd5);

    // Reset after two transfers, then restart from (0,0)
    load_c(64'sd41, 64'sd42, 64'sd43, 64'sd44);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    load_c(64'sd51, 64'sd52, 64'sd53, 64'sd54);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);

    // Saturation boundaries (truncation when the clamp is not built)
    load_c(64'sd8589934592, -64'sd8589934592, -64'sd5, 64'sd2147483647);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    load_c(-64'sd2147483648, -64'sd2147483649, 64'sd2147483648, 64'sd0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
